// File: rtl/toggle_cover_detect_if.sv
// Bundle of the enable/clear/sample inputs and the coverage outputs of the
// per-bit toggle detector. The master side is the stimulus/monitor source and
// the slave side is the detector itself.
interface toggle_cover_detect_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(2*WIDTH+1)
);
  logic                 en;
  logic                 clear;
  logic [WIDTH-1:0]     sig;
  logic [2*WIDTH-1:0]   valid;
  logic [CW-1:0]        covered;
  logic                 all_covered;

  modport master (
    output en, clear, sig,
    input  valid, covered, all_covered
  );

  modport slave (
    input  en, clear, sig,
    output valid, covered, all_covered
  );
endinterface

// File: rtl/toggle_cover_detect.sv
// Per-bit toggle detector for an 8-lane toggle-coverage reporter. Each
// monitored bit owns two lanes (even = rise, odd = fall). A hit mask and a
// running count track which points have been seen since reset or clear; with
// ONCE=1 each lane pulses at most once per clear epoch.
module toggle_cover_detect #(
  parameter int WIDTH = 4,
  parameter int ONCE  = 1,
  parameter int CW    = $clog2(2*WIDTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  toggle_cover_detect_if.slave bus
);

  localparam int              LANES  = 2*WIDTH;
  localparam logic [CW-1:0]   POINTS = CW'(LANES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  logic [1:0]        state;
  logic [WIDTH-1:0]  prev;
  logic [LANES-1:0]  hit;
  logic [LANES-1:0]  valid_q;
  logic [CW-1:0]     covered_q;
  logic              all_q;

  logic [LANES-1:0]  ev;
  logic [LANES-1:0]  fresh;
  logic [CW-1:0]     covered_next;

  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // Event lanes exist only while tracking with enable high; ARM never reports.
  always_comb begin
    ev = '0;
    if (state == TRACK && bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        ev[2*i]   = ~prev[i] &  bus.sig[i];
        ev[2*i+1] =  prev[i] & ~bus.sig[i];
      end
    end
    fresh        = ev & ~hit;
    covered_next = covered_q + popcount(fresh);
  end

  // Control, baseline, hit mask and count; reset > clear > en low > detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      prev      <= '0;
      hit       <= '0;
      valid_q   <= '0;
      covered_q <= '0;
      all_q     <= 1'b0;
    end else if (bus.clear) begin
      state     <= bus.en ? ARM : IDLE;
      hit       <= '0;
      valid_q   <= '0;
      covered_q <= '0;
      all_q     <= 1'b0;
    end else if (!bus.en) begin
      state   <= IDLE;
      valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= ARM;
          valid_q <= '0;
        end
        ARM: begin
          prev    <= bus.sig;
          state   <= TRACK;
          valid_q <= '0;
        end
        TRACK: begin
          prev      <= bus.sig;
          valid_q   <= (ONCE != 0) ? fresh : ev;
          hit       <= hit | ev;
          covered_q <= covered_next;
          all_q     <= (covered_next == POINTS);
        end
        default: begin
          state   <= IDLE;
          valid_q <= '0;
        end
      endcase
    end
  end

  assign bus.valid       = valid_q;
  assign bus.covered     = covered_q;
  assign bus.all_covered = all_q;

  // Only fresh points are ever counted, so the count is bounded by the lane count.
  always @(posedge clock) begin
    if (reset) begin
      assert (covered_q <= POINTS);
    end
  end

endmodule
